// File: rtl/fnn_pkg.sv
// Shared types and helpers for the FNN output layer: state encoding and
// sign-magnitude to two's-complement conversion.
package fnn_pkg;

    localparam int N_OUT = 10;

    typedef enum logic [1:0] {
        ST_ACC    = 2'd0,
        ST_BIAS   = 2'd1,
        ST_ARGMAX = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Negative zero (8'h80) has magnitude 0, so it naturally maps to 0.
    function automatic logic [7:0] sm2tc(input logic [7:0] sm);
        logic [7:0] mag;
        mag = {1'b0, sm[6:0]};
        if (sm[7]) begin
            return 8'd0 - mag;
        end else begin
            return mag;
        end
    endfunction

endpackage

// File: rtl/sm_mul.sv
// 8x8 sign-magnitude multiplier producing a 15-bit two's-complement product.
module sm_mul (
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [14:0] p_o
);

    logic [13:0] mag_s;

    assign mag_s = {7'd0, a_i[6:0]} * {7'd0, b_i[6:0]};
    // A zero magnitude negates to zero, which covers negative-zero operands.
    assign p_o   = (a_i[7] ^ b_i[7]) ? (15'd0 - {1'b0, mag_s}) : {1'b0, mag_s};

endmodule

// File: rtl/out_layer_argmax.sv
// FNN output layer: ten streaming MAC accumulators, bias add from the ROM,
// then a sequential argmax over the biased scores.
module out_layer_argmax
    import fnn_pkg::*;
#(
    parameter int N_OUT      = 10,
    parameter int ACC_W      = 20,
    parameter int BIAS_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [7:0]       x,
    input  logic [7:0]       w0,
    input  logic [7:0]       w1,
    input  logic [7:0]       w2,
    input  logic [7:0]       w3,
    input  logic [7:0]       w4,
    input  logic [7:0]       w5,
    input  logic [7:0]       w6,
    input  logic [7:0]       w7,
    input  logic [7:0]       w8,
    input  logic [7:0]       w9,
    input  logic [7:0]       bo0,
    input  logic [7:0]       bo1,
    input  logic [7:0]       bo2,
    input  logic [7:0]       bo3,
    input  logic [7:0]       bo4,
    input  logic [7:0]       bo5,
    input  logic [7:0]       bo6,
    input  logic [7:0]       bo7,
    input  logic [7:0]       bo8,
    input  logic [7:0]       bo9,
    output logic             out_valid,
    output logic [3:0]       out_class,
    output logic [ACC_W-1:0] out_score
);

    logic [7:0]              w_s        [N_OUT];
    logic [7:0]              bo_s       [N_OUT];
    logic [14:0]             prod_s     [N_OUT];
    logic [7:0]              bias_tc_s  [N_OUT];
    logic signed [ACC_W-1:0] prod_ext_s [N_OUT];
    logic signed [ACC_W-1:0] bias_ext_s [N_OUT];
    logic signed [ACC_W-1:0] acc_q      [N_OUT];
    logic signed [ACC_W-1:0] acc_d      [N_OUT];

    logic signed [ACC_W-1:0] best_q, best_d;
    logic [3:0]              best_cls_q, best_cls_d;
    logic [3:0]              idx_q, idx_d;
    state_e                  state_q, state_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic [3:0]              out_class_q, out_class_d;
    logic [ACC_W-1:0]        out_score_q, out_score_d;

    assign w_s  = '{w0, w1, w2, w3, w4, w5, w6, w7, w8, w9};
    assign bo_s = '{bo0, bo1, bo2, bo3, bo4, bo5, bo6, bo7, bo8, bo9};

    for (genvar k = 0; k < N_OUT; k++) begin : g_lane
        sm_mul u_mul (
            .a_i (x),
            .b_i (w_s[k]),
            .p_o (prod_s[k])
        );
        assign bias_tc_s[k]  = sm2tc(bo_s[k]);
        assign prod_ext_s[k] = {{(ACC_W-15){prod_s[k][14]}}, prod_s[k]};
        assign bias_ext_s[k] = {{(ACC_W-8){bias_tc_s[k][7]}}, bias_tc_s[k]} << BIAS_SHIFT;
    end

    // Next-state, accumulator and result logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        best_d      = best_q;
        best_cls_d  = best_cls_q;
        out_valid_d = 1'b0;
        out_class_d = out_class_q;
        out_score_d = out_score_q;
        for (int k = 0; k < N_OUT; k++) begin
            acc_d[k] = acc_q[k];
        end

        case (state_q)
            ST_ACC: begin
                if (in_valid && in_ready_q) begin
                    for (int k = 0; k < N_OUT; k++) begin
                        acc_d[k] = acc_q[k] + prod_ext_s[k];
                    end
                    if (in_last) begin
                        state_d = ST_BIAS;
                    end else begin
                        state_d = ST_ACC;
                    end
                end else begin
                    state_d = ST_ACC;
                end
            end
            ST_BIAS: begin
                for (int k = 0; k < N_OUT; k++) begin
                    acc_d[k] = acc_q[k] + bias_ext_s[k];
                end
                idx_d   = 4'd0;
                state_d = ST_ARGMAX;
            end
            ST_ARGMAX: begin
                // Strict compare keeps the lowest index on ties.
                if (idx_q == 4'd0) begin
                    best_d     = acc_q[0];
                    best_cls_d = 4'd0;
                end else if (acc_q[idx_q] > best_q) begin
                    best_d     = acc_q[idx_q];
                    best_cls_d = idx_q;
                end else begin
                    best_d     = best_q;
                    best_cls_d = best_cls_q;
                end
                if (idx_q == 4'(N_OUT - 1)) begin
                    idx_d       = 4'd0;
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    out_class_d = best_cls_d;
                    out_score_d = best_d;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_DONE: begin
                for (int k = 0; k < N_OUT; k++) begin
                    acc_d[k] = '0;
                end
                state_d = ST_ACC;
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase

        in_ready_d = (state_d == ST_ACC);
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            idx_q       <= 4'd0;
            best_q      <= '0;
            best_cls_q  <= 4'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_class_q <= 4'd0;
            out_score_q <= '0;
            for (int k = 0; k < N_OUT; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            best_q      <= best_d;
            best_cls_q  <= best_cls_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_class_q <= out_class_d;
            out_score_q <= out_score_d;
            for (int k = 0; k < N_OUT; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_score = out_score_q;

endmodule

// File: tb/tb_out_layer_argmax.sv
// Self-checking bench for out_layer_argmax: directed and random frames scored
// against an integer reference of the output layer.
module tb_out_layer_argmax;

    localparam int ACC_W      = 20;
    localparam int NO         = 10;
    localparam int BIAS_SHIFT = 0;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [7:0]       x;
    logic [7:0]       w  [NO];
    logic [7:0]       bo [NO];
    logic             out_valid;
    logic [3:0]       out_class;
    logic [ACC_W-1:0] out_score;

    int tests = 0;
    int fails = 0;
    int m_acc    [NO];
    int rom_bias [NO] = '{-3, -46, 35, 2, 21, 3, -31, -70, 86, 7};
    int cur_bias [NO];
    logic [7:0] wv [NO];
    int               exp_cls;
    logic [ACC_W-1:0] exp_score;

    always #5 clk = ~clk;

    out_layer_argmax #(.N_OUT(NO), .ACC_W(ACC_W), .BIAS_SHIFT(BIAS_SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .x(x),
        .w0(w[0]), .w1(w[1]), .w2(w[2]), .w3(w[3]), .w4(w[4]),
        .w5(w[5]), .w6(w[6]), .w7(w[7]), .w8(w[8]), .w9(w[9]),
        .bo0(bo[0]), .bo1(bo[1]), .bo2(bo[2]), .bo3(bo[3]), .bo4(bo[4]),
        .bo5(bo[5]), .bo6(bo[6]), .bo7(bo[7]), .bo8(bo[8]), .bo9(bo[9]),
        .out_valid(out_valid), .out_class(out_class), .out_score(out_score)
    );

    function automatic int sm_val(input logic [7:0] v);
        int m;
        m = int'(v[6:0]);
        return v[7] ? -m : m;
    endfunction

    function automatic logic [7:0] to_sm(input int v);
        logic [7:0] r;
        if (v < 0) r = {1'b1, 7'(-v)};
        else       r = {1'b0, 7'(v)};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_bias(input bit zero);
        for (int k = 0; k < NO; k++) begin
            cur_bias[k] = zero ? 0 : rom_bias[k];
            bo[k]       = to_sm(cur_bias[k]);
        end
    endtask

    // Reference: biased, wrapped scores; first maximum wins.
    task automatic predict();
        logic signed [ACC_W-1:0] s;
        logic signed [ACC_W-1:0] best;
        best    = '0;
        exp_cls = 0;
        for (int k = 0; k < NO; k++) begin
            s = ACC_W'(m_acc[k] + cur_bias[k] * (1 << BIAS_SHIFT));
            if (k == 0 || s > best) begin
                best    = s;
                exp_cls = k;
            end
        end
        exp_score = best;
    endtask

    // Returns 1 ns after the edge that accepted the beat.
    task automatic beat(input logic [7:0] xv, input logic last, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            x        = 8'($urandom);
            in_last  = 1'b1;
            @(posedge clk); #1;
        end
        x       = xv;
        in_last = last;
        for (int k = 0; k < NO; k++) w[k] = wv[k];
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < NO; k++) m_acc[k] += sm_val(xv) * sm_val(wv[k]);
    endtask

    // Called 1 ns after the last beat's accepting edge T.
    task automatic finish_frame(input string tag, input bit hold);
        predict();
        if (hold) begin
            in_valid = 1'b1;
            x        = 8'($urandom);
            in_last  = 1'($urandom);
            for (int k = 0; k < NO; k++) w[k] = 8'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        for (int k = 0; k < 12; k++) begin
            chk({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
            chk({tag, "_valid_timing"}, {31'd0, out_valid}, {31'd0, (k == 11)});
            if (k < 11) begin
                @(posedge clk); #1;
            end else begin
                chk({tag, "_class"}, {28'd0, out_class}, 32'(exp_cls));
                chk({tag, "_score"}, {12'd0, out_score}, {12'd0, exp_score});
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
        chk({tag, "_valid_pulse_end"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_class_hold"}, {28'd0, out_class}, 32'(exp_cls));
        for (int k = 0; k < NO; k++) m_acc[k] = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=hang expected=finish");
        $fatal(1);
    end

    initial begin
        int nb;
        int pulses;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        x        = 8'd0;
        for (int k = 0; k < NO; k++) begin
            w[k]     = 8'd0;
            wv[k]    = 8'd0;
            m_acc[k] = 0;
        end
        set_bias(1'b0);
        #12;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_class", {28'd0, out_class}, 32'd0);
        chk("rst_score", {12'd0, out_score}, 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Bias-only frame.
        for (int k = 0; k < NO; k++) wv[k] = 8'h00;
        beat(8'h01, 1'b1, 0);
        finish_frame("bias_only", 1'b0);
        chk("bias_only_class_const", {28'd0, out_class}, 32'd8);
        chk("bias_only_score_const", {12'd0, out_score}, 32'd86);

        // Weight dominates.
        wv[3] = 8'h7F;
        beat(8'h02, 1'b1, 1);
        finish_frame("weight_dom", 1'b0);
        chk("weight_dom_class_const", {28'd0, out_class}, 32'd3);
        chk("weight_dom_score_const", {12'd0, out_score}, 32'd256);

        // Reset in the middle of ARGMAX aborts the frame.
        for (int k = 0; k < NO; k++) wv[k] = 8'h11;
        beat(8'h09, 1'b1, 0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_class", {28'd0, out_class}, 32'd0);
        chk("abort_score", {12'd0, out_score}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        #2 rst_n = 1'b1;
        for (int k = 0; k < NO; k++) m_acc[k] = 0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
        chk("abort_no_pulse", 32'(pulses), 32'd0);

        // Tie and negative zero with zero biases.
        set_bias(1'b1);
        for (int k = 0; k < NO; k++) wv[k] = 8'h7F;
        beat(8'h80, 1'b0, 0);
        for (int k = 0; k < NO; k++) wv[k] = 8'h00;
        beat(8'h05, 1'b1, 0);
        finish_frame("tie_negzero", 1'b0);
        chk("tie_class_const", {28'd0, out_class}, 32'd0);
        chk("tie_score_const", {12'd0, out_score}, 32'd0);

        // Multi-beat with gaps and in_valid held through the result phase.
        set_bias(1'b0);
        for (int k = 0; k < NO; k++) wv[k] = 8'($urandom);
        wv[0] = 8'h04;
        beat(8'h83, 1'b0, 2);
        for (int k = 0; k < NO; k++) wv[k] = 8'($urandom);
        beat(8'($urandom), 1'b0, 3);
        for (int k = 0; k < NO; k++) wv[k] = 8'($urandom);
        beat(8'($urandom), 1'b1, 1);
        finish_frame("multi_hold", 1'b1);

        // Random back-to-back frames.
        for (int f = 0; f < 6; f++) begin
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                for (int k = 0; k < NO; k++) begin
                    wv[k] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
                end
                beat(($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom), (b == nb - 1), 0);
            end
            finish_frame("random_b2b", 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
